// File: rtl/mnist_tile_scheduler.sv
// MNIST tile scheduler: walks the input vector in tiles, fires the
// systolic array per tile, accumulates class sums and runs an argmax.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   start, image_num      : start request (rising edge) and image index
//   ready                 : idle and accepting start
//   tile_req/ack/idx/len  : tile load handshake towards the loader
//   image_idx             : latched image index
//   arr_start/done/result : array compute pulse, completion, partial sums
//   result_valid          : one-cycle pulse when classification is done
//   class_idx, classes    : winning class (binary and one-hot)
//   hex_out               : active-low 7-seg {g,f,e,d,c,b,a}
module mnist_tile_scheduler #(
  parameter int DATA_WIDTH = 16,
  parameter int ARRAY_W    = 10,
  parameter int ARRAY_L    = 13,
  parameter int VEC_LEN    = 784,
  parameter int ACC_WIDTH  = 32,
  parameter int IMAGES     = 10
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic                                             start,
  input  logic [3:0]                                       image_num,
  output logic                                             ready,
  output logic                                             tile_req,
  input  logic                                             tile_ack,
  output logic [$clog2((VEC_LEN+ARRAY_L-1)/ARRAY_L)-1:0]   tile_idx,
  output logic [$clog2(ARRAY_L+1)-1:0]                     tile_len,
  output logic [3:0]                                       image_idx,
  output logic                                             arr_start,
  input  logic                                             arr_done,
  input  logic [ARRAY_W*DATA_WIDTH-1:0]                    arr_result,
  output logic                                             result_valid,
  output logic [3:0]                                       class_idx,
  output logic [ARRAY_W-1:0]                               classes,
  output logic [6:0]                                       hex_out
);

  localparam int NUM_TILES = (VEC_LEN + ARRAY_L - 1) / ARRAY_L;
  localparam int LAST_LEN  = VEC_LEN - (NUM_TILES - 1) * ARRAY_L;
  localparam int TW        = $clog2(NUM_TILES);
  localparam int LW        = $clog2(ARRAY_L + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_COMP   = 3'd2;
  localparam logic [2:0] S_ACCUM  = 3'd3;
  localparam logic [2:0] S_ARGMAX = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [6:0] BLANK = 7'b1111111;

  logic [2:0]                   r_state;
  logic                         r_start_q;
  logic                         r_ready;
  logic                         r_tile_req;
  logic [TW-1:0]                r_tile_idx;
  logic [LW-1:0]                r_tile_len;
  logic [3:0]                   r_image_idx;
  logic                         r_arr_start;
  logic                         r_result_valid;
  logic [3:0]                   r_class_idx;
  logic [ARRAY_W-1:0]           r_classes;
  logic [6:0]                   r_hex;
  logic signed [DATA_WIDTH-1:0] r_res [ARRAY_W];
  logic signed [ACC_WIDTH-1:0]  r_acc [ARRAY_W];
  logic signed [ACC_WIDTH-1:0]  r_best;
  logic [3:0]                   r_bidx;
  logic [3:0]                   r_cnt;

  logic                         w_edge;
  logic                         w_img_ok;

  assign w_edge   = start & ~r_start_q;
  assign w_img_ok = 32'(image_num) < IMAGES;

  assign ready        = r_ready;
  assign tile_req     = r_tile_req;
  assign tile_idx     = r_tile_idx;
  assign tile_len     = r_tile_len;
  assign image_idx    = r_image_idx;
  assign arr_start    = r_arr_start;
  assign result_valid = r_result_valid;
  assign class_idx    = r_class_idx;
  assign classes      = r_classes;
  assign hex_out      = r_hex;

  function automatic logic [6:0] f_digit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = BLANK;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk) begin
    // Edge detector follows start in every state, so a start held
    // through a run (or through reset) never retriggers.
    r_start_q <= start;
    if (reset) begin
      r_state        <= S_IDLE;
      r_ready        <= 1'b1;
      r_tile_req     <= 1'b0;
      r_tile_idx     <= '0;
      r_tile_len     <= LW'(ARRAY_L);
      r_image_idx    <= '0;
      r_arr_start    <= 1'b0;
      r_result_valid <= 1'b0;
      r_class_idx    <= '0;
      r_classes      <= '0;
      r_hex          <= BLANK;
      r_best         <= '0;
      r_bidx         <= '0;
      r_cnt          <= '0;
      for (int c = 0; c < ARRAY_W; c++) begin
        r_acc[c] <= '0;
        r_res[c] <= '0;
      end
    end else begin
      r_result_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_edge && w_img_ok) begin
            r_image_idx <= image_num;
            r_tile_idx  <= '0;
            r_tile_len  <= (NUM_TILES == 1) ? LW'(LAST_LEN)
                                            : LW'(ARRAY_L);
            r_ready     <= 1'b0;
            r_tile_req  <= 1'b1;
            r_classes   <= '0;
            r_hex       <= BLANK;
            for (int c = 0; c < ARRAY_W; c++) r_acc[c] <= '0;
            r_state     <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (tile_ack) begin
            r_tile_req  <= 1'b0;
            r_arr_start <= 1'b1;
            r_state     <= S_COMP;
          end
        end
        S_COMP: begin
          r_arr_start <= 1'b0;
          // A done pulse coincident with our own start pulse is stale.
          if (arr_done && !r_arr_start) begin
            for (int c = 0; c < ARRAY_W; c++)
              r_res[c] <= arr_result[c*DATA_WIDTH +: DATA_WIDTH];
            r_state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          for (int c = 0; c < ARRAY_W; c++)
            r_acc[c] <= r_acc[c] + ACC_WIDTH'(r_res[c]);
          if (r_tile_idx == TW'(NUM_TILES - 1)) begin
            r_cnt   <= '0;
            r_state <= S_ARGMAX;
          end else begin
            r_tile_idx <= r_tile_idx + 1'b1;
            r_tile_len <= (r_tile_idx == TW'(NUM_TILES - 2))
                          ? LW'(LAST_LEN) : LW'(ARRAY_L);
            r_tile_req <= 1'b1;
            r_state    <= S_LOAD;
          end
        end
        S_ARGMAX: begin
          if (r_cnt == 4'd0) begin
            r_best <= r_acc[0];
            r_bidx <= '0;
          end else if (r_acc[r_cnt] > r_best) begin
            // Strictly greater keeps the lowest index on ties.
            r_best <= r_acc[r_cnt];
            r_bidx <= r_cnt;
          end
          if (r_cnt == 4'(ARRAY_W - 1)) r_state <= S_DONE;
          r_cnt <= r_cnt + 1'b1;
        end
        S_DONE: begin
          r_class_idx    <= r_bidx;
          r_classes      <= {{(ARRAY_W-1){1'b0}}, 1'b1} << r_bidx;
          r_hex          <= f_digit(r_bidx);
          r_result_valid <= 1'b1;
          r_ready        <= 1'b1;
          r_state        <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mnist_tile_scheduler.sv
// Testbench for mnist_tile_scheduler: directed runs with a randomized
// array model, checked against per-class sums computed in the bench.
module tb_mnist_tile_scheduler;

  localparam int NT = 61;
  localparam int AW = 10;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [3:0]    image_num;
  logic          ready;
  logic          tile_req;
  logic          tile_ack;
  logic [5:0]    tile_idx;
  logic [3:0]    tile_len;
  logic [3:0]    image_idx;
  logic          arr_start;
  logic          arr_done;
  logic [AW*DW-1:0] arr_result;
  logic          result_valid;
  logic [3:0]    class_idx;
  logic [AW-1:0] classes;
  logic [6:0]    hex_out;

  int checks = 0;
  int errors = 0;
  int tdata [NT][AW];
  logic [6:0] segtab [0:9];

  always #5 clk = ~clk;

  mnist_tile_scheduler dut (
    .clk(clk), .reset(reset), .start(start), .image_num(image_num),
    .ready(ready), .tile_req(tile_req), .tile_ack(tile_ack),
    .tile_idx(tile_idx), .tile_len(tile_len), .image_idx(image_idx),
    .arr_start(arr_start), .arr_done(arr_done),
    .arr_result(arr_result), .result_valid(result_valid),
    .class_idx(class_idx), .classes(classes), .hex_out(hex_out)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // 0: class7=+1; 1: all zero; 2: -5 except class9=-1;
  // 3: full-range random; 4: class2=+2
  task automatic fill(input int mode);
    for (int t = 0; t < NT; t++)
      for (int c = 0; c < AW; c++)
        case (mode)
          0: tdata[t][c] = (c == 7) ? 1 : 0;
          1: tdata[t][c] = 0;
          2: tdata[t][c] = (c == 9) ? -1 : -5;
          3: tdata[t][c] = $signed(16'($urandom));
          default: tdata[t][c] = (c == 2) ? 2 : 0;
        endcase
  endtask

  task automatic check_reset_outputs(input string p);
    chk({p, "_ready"}, 64'(ready), 64'd1);
    chk({p, "_tile_req"}, 64'(tile_req), 64'd0);
    chk({p, "_arr_start"}, 64'(arr_start), 64'd0);
    chk({p, "_classes"}, 64'(classes), 64'd0);
    chk({p, "_hex"}, 64'(hex_out), 64'h7f);
    chk({p, "_tile_idx"}, 64'(tile_idx), 64'd0);
    chk({p, "_rvalid"}, 64'(result_valid), 64'd0);
  endtask

  task automatic run(input int img, input int ack_dly, input int dd,
                     input bit pokes, input int abort_tile);
    longint sum [AW];
    longint bv;
    int bi, nstart, w, pend, cur, lat;
    bit fin;
    for (int c = 0; c < AW; c++) begin
      sum[c] = 0;
      for (int t = 0; t < NT; t++) sum[c] += tdata[t][c];
    end
    bv = sum[0];
    bi = 0;
    for (int c = 1; c < AW; c++)
      if (sum[c] > bv) begin
        bv = sum[c];
        bi = c;
      end
    lat = 255 + ack_dly + NT * (dd - 1);
    nstart = 0; w = 0; pend = 0; cur = 0; fin = 0;
    arr_done = 0;
    tile_ack = (ack_dly == 0);
    @(negedge clk);
    start = 0;
    @(negedge clk);
    start = 1;
    image_num = 4'(img);
    for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc == 0) begin
        chk("accept_ready", 64'(ready), 64'd0);
        chk("accept_classes", 64'(classes), 64'd0);
        chk("accept_hex", 64'(hex_out), 64'h7f);
      end
      if (cyc == 5) image_num = 4'(img + 1);
      if (pokes) begin
        if (cyc == 30 || cyc == 100) start = 0;
        if (cyc == 31 || cyc == 102) start = 1;
      end
      arr_done = 0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          arr_done = 1;
          for (int c = 0; c < AW; c++)
            arr_result[c*DW +: DW] = DW'(tdata[cur][c]);
        end
      end
      if (arr_start) begin
        cur = nstart;
        nstart++;
        pend = dd;
        if (cur == abort_tile) begin
          chk("abort_tile_idx", 64'(tile_idx), 64'(abort_tile));
          arr_done = 0;
          reset = 1;
          @(posedge clk);
          #1;
          reset = 0;
          check_reset_outputs("midrst");
          return;
        end
      end
      if (tile_req) begin
        chk("tile_idx", 64'(tile_idx), 64'(nstart));
        chk("tile_len", 64'(tile_len),
            (nstart == NT - 1) ? 64'd4 : 64'd13);
        chk("image_idx", 64'(image_idx), 64'(img));
        if (nstart == 0 && w < ack_dly) begin
          tile_ack = 0;
          w++;
        end else begin
          tile_ack = 1;
        end
      end
      if (result_valid) begin
        fin = 1;
        chk("latency", 64'(cyc), 64'(lat));
        chk("arr_starts", 64'(nstart), 64'(NT));
        chk("class_idx", 64'(class_idx), 64'(bi));
        chk("classes", 64'(classes), 64'(1) << bi);
        chk("hex_out", 64'(hex_out), 64'(segtab[bi]));
      end
    end
    chk("run_finished", 64'(fin), 64'd1);
    @(posedge clk);
    #1;
    chk("rvalid_pulse", 64'(result_valid), 64'd0);
    chk("ready_after", 64'(ready), 64'd1);
    chk("tile_req_idle", 64'(tile_req), 64'd0);
  endtask

  initial begin
    segtab[0] = 7'b1000000; segtab[1] = 7'b1111001;
    segtab[2] = 7'b0100100; segtab[3] = 7'b0110000;
    segtab[4] = 7'b0011001; segtab[5] = 7'b0010010;
    segtab[6] = 7'b0000010; segtab[7] = 7'b1111000;
    segtab[8] = 7'b0000000; segtab[9] = 7'b0010000;
    reset = 1; start = 1; image_num = 4'd2;
    tile_ack = 1; arr_done = 0; arr_result = '0;

    // Reset with start held high: no run afterwards.
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("held_start_after_reset", 64'(tile_req), 64'd0);
    end

    // Nominal: class 7, exact latency.
    fill(0);
    run(3, 0, 1, 0, -1);
    chk("nominal_classes", 64'(classes), 64'b0010000000);
    chk("nominal_hex", 64'(hex_out), 64'b1111000);

    // All-zero tie and negative sums.
    fill(1);
    run(0, 0, 1, 0, -1);
    fill(2);
    run(9, 0, 1, 0, -1);
    chk("neg_classes", 64'(classes), 64'b1000000000);

    // Handshake stalls with random data.
    fill(3);
    run(5, 5, 20, 0, -1);

    // Extra start edges mid-run, then start held after the run.
    fill(3);
    run(4, 0, 1, 1, -1);
    repeat (8) begin
      @(posedge clk);
      #1;
      chk("held_start_idle", 64'(tile_req), 64'd0);
    end

    // Out-of-range image index is ignored.
    @(negedge clk);
    start = 0;
    image_num = 4'd12;
    @(negedge clk);
    start = 1;
    repeat (10) begin
      @(posedge clk);
      #1;
      chk("bad_img_req", 64'(tile_req), 64'd0);
      chk("bad_img_ready", 64'(ready), 64'd1);
    end

    // Reset in COMPUTE on tile 20, then a fresh run.
    fill(4);
    run(6, 0, 1, 0, 20);
    run(1, 0, 1, 0, -1);
    chk("after_rst_classes", 64'(classes), 64'b0000000100);

    // Randomized runs.
    for (int k = 0; k < 2; k++) begin
      fill(3);
      run($urandom_range(0, 9), $urandom_range(0, 3),
          $urandom_range(1, 4), 0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
